// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

  // Parity modes
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Receiver frame states
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_t;

  // System clocks per bit period
  function automatic int unsigned baud_cnt_max(input int unsigned clk, input int unsigned bps);
    return clk / bps;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// RX front end: 2-FF synchroniser, falling-edge detect, baud counter and 3-tap majority vote.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_CNT_MAX = 5208
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic rx,
  input  logic run,        // high whenever the frame FSM is outside IDLE
  output logic start_edge, // falling edge on the synchronised line
  output logic bit_tick,   // one-cycle strobe at the decision point of each bit
  output logic bit_val     // majority of the three mid-bit samples, valid with bit_tick
);

  localparam int unsigned CNT_W = $clog2(BAUD_CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] MID      = CNT_W'(BAUD_CNT_MAX / 2 - 1);
  localparam logic [CNT_W-1:0] MID_M1   = CNT_W'(BAUD_CNT_MAX / 2 - 2);
  localparam logic [CNT_W-1:0] MID_P1   = CNT_W'(BAUD_CNT_MAX / 2);

  logic             rx_meta_q, rx_sync_q, rx_hist_q;
  logic [CNT_W-1:0] cnt_q;
  logic             smp0_q, smp1_q;

  // Synchroniser plus history flop; idle-high reset avoids a spurious start edge
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_hist_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_hist_q <= rx_sync_q;
    end
  end

  // Baud counter: held at 0 in IDLE, so it starts from 0 on entry to START
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else if (!run || (cnt_q == CNT_LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Capture the first two of the three mid-bit samples
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      smp0_q <= 1'b1;
      smp1_q <= 1'b1;
    end else begin
      if (run && (cnt_q == MID_M1)) smp0_q <= rx_sync_q;
      if (run && (cnt_q == MID))    smp1_q <= rx_sync_q;
    end
  end

  assign start_edge = rx_hist_q & ~rx_sync_q;
  assign bit_tick   = run && (cnt_q == MID_P1);
  // Third sample is the live synchronised value at MID+1
  assign bit_val    = (smp0_q & smp1_q) | (smp0_q & rx_sync_q) | (smp1_q & rx_sync_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM, shift register, parity/stop checks and one-word
// output holding register with valid/ready handshake.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned UART_BPS  = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_valid,
  input  logic                 po_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int unsigned IDX_W        = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  rx_state_t            state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 done_q, done_d;

  logic                 start_edge, bit_tick, bit_val;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_out_q, brk_q, ovr_q;

  logic                 data_xor, par_exp, word_perr, word_brk;

  uart_bit_sampler #(
    .BAUD_CNT_MAX (BAUD_CNT_MAX)
  ) u_sampler (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .rx         (rx),
    .run        (state_q != StIdle),
    .start_edge (start_edge),
    .bit_tick   (bit_tick),
    .bit_val    (bit_val)
  );

  // Frame state and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  // Next-state: one decision per bit_tick, LSB-first shift, stop bits accumulate frame error
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d = StStart;
          idx_d   = '0;
          ferr_d  = 1'b0;
        end
      end
      StStart: begin
        if (bit_tick) begin
          // A high majority means the edge was a glitch
          state_d = bit_val ? StIdle : StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_tick) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? StParity : StStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_tick) begin
          par_d   = bit_val;
          idx_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_tick) begin
          if (!bit_val) ferr_d = 1'b1;
          if (idx_q == LAST_STOP) begin
            // Leave half a bit early so a back-to-back start edge is not missed
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status of the just-completed word
  always_comb begin
    data_xor  = ^shift_q;
    par_exp   = (PARITY == PAR_ODD) ? ~data_xor : data_xor;
    word_perr = (PARITY != PAR_NONE) && (par_q != par_exp);
    word_brk  = (shift_q == '0) && ((PARITY == PAR_NONE) || !par_q) && ferr_q;
  end

  // Holding register: load when empty or being emptied, else drop the word and flag overrun
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_out_q <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      ovr_q <= done_q && valid_q && !po_ready;
      if (done_q && (!valid_q || po_ready)) begin
        data_q     <= shift_q;
        valid_q    <= 1'b1;
        perr_q     <= word_perr;
        ferr_out_q <= ferr_q;
        brk_q      <= word_brk;
      end else if (valid_q && po_ready) begin
        valid_q    <= 1'b0;
        perr_q     <= 1'b0;
        ferr_out_q <= 1'b0;
        brk_q      <= 1'b0;
      end
    end
  end

  assign po_data    = data_q;
  assign po_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_out_q;
  assign break_det  = brk_q;
  assign overrun    = ovr_q;

endmodule
